led_effect_engine: RTL
======================

LED_EFFECT_ENGINE -- requirements
Module: led_effect_engine

Interface
REQ-001 Parameter N_LEDS, default 10: LED count and width of gauge/output buses; SHALL be legal for 1..32.
REQ-002 Parameter TICK_DIV, default 4: clock cycles per animation frame tick; SHALL be legal for values >= 2.
REQ-003 Parameter FLASH_FRAMES, default 8: frame-tick count of one celebration animation; SHALL be legal for values >= 1.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 gauge_in  input  N_LEDS  fuel-gauge bit pattern.
REQ-007 disp_mode  input  3  display mode select.
REQ-008 personal_best  input  1  personal-best event, sampled every clock edge.
REQ-009 global_best  input  1  global-best event, sampled every clock edge.
REQ-010 led_out  output  N_LEDS  registered LED drive.
REQ-011 anim_busy  output  1  registered; high while a celebration animation runs.

Function
REQ-012 Frame divider SHALL count 0..TICK_DIV-1 and wrap; tick is high for one cycle when the count equals TICK_DIV-1.
REQ-013 Controller SHALL be an FSM with states NORMAL, PB_ANIM and GB_ANIM, plus a frame counter of width clog2(FLASH_FRAMES+1).
REQ-014 NORMAL: global_best high at an edge SHALL enter GB_ANIM; otherwise personal_best high SHALL enter PB_ANIM; frame counter cleared to 0 on entry.
REQ-015 PB_ANIM: global_best high SHALL preempt to GB_ANIM with frame counter 0; personal_best high SHALL restart the frame counter at 0.
REQ-016 GB_ANIM: global_best high SHALL restart the frame counter at 0; personal_best SHALL be ignored.
REQ-017 In either ANIM state, each tick SHALL increment the frame counter; a tick with counter == FLASH_FRAMES-1 SHALL return the FSM to NORMAL, unless a retrigger or preempt occurs on the same edge, which takes priority.
REQ-018 led_out SHALL be registered; its value after edge k is a function of state, counters and inputs as they stood after edge k-1, giving 1-cycle latency from any input change.
REQ-019 GB_ANIM pattern: all ones on even frames, all zeros on odd frames.
REQ-020 PB_ANIM pattern: bits at even indices set on even frames; bits at odd indices set on odd frames.
REQ-021 NORMAL, disp_mode 0: led_out = gauge_in.
REQ-022 NORMAL, disp_mode 1: thermometer output; the lowest popcount(gauge_in) bits set, rest clear.
REQ-023 NORMAL, disp_mode 2: chase; a single bit at position pos; pos SHALL advance on each tick and wrap from N_LEDS-1 to 0.
REQ-024 NORMAL, disp_mode 3: bounce; a single bit at pos; pos SHALL move in direction dir on each tick and reverse dir at 0 and N_LEDS-1 with no repeated frame at the ends; with N_LEDS=1, pos SHALL stay at 0.
REQ-025 NORMAL, disp_mode 4: blink; led_out = gauge_in when the blink phase is 1, else 0; phase SHALL toggle on each tick.
REQ-026 NORMAL, disp_mode 5-7: led_out = 0.
REQ-027 pos, dir, blink phase and the divider SHALL run continuously in all states and modes; a mode change SHALL NOT reset them.
REQ-028 anim_busy SHALL be 1 exactly when the registered state is PB_ANIM or GB_ANIM.

Reset
REQ-029 rst high at an edge SHALL force: led_out=0, anim_busy=0, state NORMAL, divider=0, frame counter=0, pos=0, dir=up, blink phase=0.
REQ-030 Reset SHALL override all events on the same edge; reset asserted mid-animation SHALL abort the animation immediately.
REQ-031 The first tick after reset release SHALL occur TICK_DIV edges after the last reset edge.

Verification (N_LEDS=10, TICK_DIV=4, FLASH_FRAMES=4)
REQ-032 Reset, then mode 0 with gauge_in=10'b1110000000 -> led_out=10'b1110000000 one cycle later; anim_busy=0.
REQ-033 Mode 1 with gauge_in=10'b1010000001 -> led_out=10'b0000000111.
REQ-034 Mode 2 for 11 ticks -> pos sequence 0,1,...,9,0.
REQ-035 Mode 3 for 19 ticks -> pos sequence 0..9,8..0.
REQ-036 One-cycle personal_best pulse -> anim_busy=1 for 4 ticks; led_out alternates 10'b0101010101/10'b1010101010; then returns to the mode pattern.
REQ-037 global_best pulse during PB_ANIM -> GB_ANIM with all-ones/zeros for a full 4 frames; a later personal_best pulse is ignored; rst asserted mid-animation -> led_out=0, anim_busy=0 on the next edge.

Source files
------------

// File: rtl/led_effect_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : led_effect_engine_if
// Brief    : Gauge/mode/event inputs and LED outputs of the LED effect engine.
// Revision : 1.0 - initial release
// ============================================================================
interface led_effect_engine_if #(
  parameter int N_LEDS = 10
);
  logic [N_LEDS-1:0] gauge_in;
  logic [2:0]        disp_mode;
  logic              personal_best;
  logic              global_best;
  logic [N_LEDS-1:0] led_out;
  logic              anim_busy;

  modport master (
    output gauge_in,
    output disp_mode,
    output personal_best,
    output global_best,
    input  led_out,
    input  anim_busy
  );

  modport slave (
    input  gauge_in,
    input  disp_mode,
    input  personal_best,
    input  global_best,
    output led_out,
    output anim_busy
  );
endinterface
`default_nettype wire

// File: rtl/led_effect_engine.sv
`default_nettype none
// ============================================================================
// Module   : led_effect_engine
// Brief    : Fuel-gauge LED display modes with personal/global-best animations.
// Revision : 1.0 - initial release
// ============================================================================
module led_effect_engine #(
  parameter int N_LEDS       = 10,
  parameter int TICK_DIV     = 4,
  parameter int FLASH_FRAMES = 8
) (
  input wire clk,
  input wire rst,
  led_effect_engine_if.slave bus
);

  localparam int c_DIV_W = $clog2(TICK_DIV);
  localparam int c_FRM_W = $clog2(FLASH_FRAMES + 1);
  localparam int c_POS_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
  localparam int c_CNT_W = $clog2(N_LEDS + 1);

  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(TICK_DIV - 1);
  localparam logic [c_FRM_W-1:0] c_FRM_LAST = c_FRM_W'(FLASH_FRAMES - 1);
  localparam logic [c_POS_W-1:0] c_POS_LAST = c_POS_W'(N_LEDS - 1);

  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    PB_ANIM = 2'd1,
    GB_ANIM = 2'd2
  } state_t;

  // Elaboration-time guards on the legal parameter ranges.
  generate
    if (N_LEDS < 1 || N_LEDS > 32) begin : g_badNLeds
      $error("led_effect_engine: N_LEDS must be within 1..32");
    end
    if (TICK_DIV < 2) begin : g_badTickDiv
      $error("led_effect_engine: TICK_DIV must be at least 2");
    end
    if (FLASH_FRAMES < 1) begin : g_badFlashFrames
      $error("led_effect_engine: FLASH_FRAMES must be at least 1");
    end
  endgenerate

  logic [c_DIV_W-1:0] r_divCnt;
  logic               w_tick;

  state_t             r_state;
  state_t             w_stateNext;
  logic [c_FRM_W-1:0] r_frameCnt;
  logic [c_FRM_W-1:0] w_frameNext;

  logic [c_POS_W-1:0] r_chasePos;
  logic [c_POS_W-1:0] r_bouncePos;
  logic [c_POS_W-1:0] w_bounceNext;
  logic               r_dirUp;
  logic               w_dirUpNext;
  logic               r_phase;

  logic [c_CNT_W-1:0] w_popCnt;
  logic [N_LEDS-1:0]  w_ledNext;
  logic [N_LEDS-1:0]  r_ledOut;
  logic               r_animBusy;

  // --------------------------------------------------------------------------
  // Frame tick divider
  // --------------------------------------------------------------------------
  assign w_tick = (r_divCnt == c_DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_divCnt <= '0;
    end else if (w_tick) begin
      r_divCnt <= '0;
    end else begin
      r_divCnt <= r_divCnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Free-running animation timebase: chase and bounce keep independent
  // positions so each mode always resumes its own sequence.
  // --------------------------------------------------------------------------
  always_comb begin
    w_bounceNext = r_bouncePos;
    w_dirUpNext  = r_dirUp;
    if (N_LEDS > 1) begin
      if (r_dirUp) begin
        if (r_bouncePos == c_POS_LAST) begin
          w_bounceNext = r_bouncePos - 1'b1;
          w_dirUpNext  = 1'b0;
        end else begin
          w_bounceNext = r_bouncePos + 1'b1;
        end
      end else begin
        if (r_bouncePos == '0) begin
          w_bounceNext = r_bouncePos + 1'b1;
          w_dirUpNext  = 1'b1;
        end else begin
          w_bounceNext = r_bouncePos - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_chasePos  <= '0;
      r_bouncePos <= '0;
      r_dirUp     <= 1'b1;
      r_phase     <= 1'b0;
    end else if (w_tick) begin
      r_chasePos  <= (r_chasePos == c_POS_LAST) ? '0 : r_chasePos + 1'b1;
      r_bouncePos <= w_bounceNext;
      r_dirUp     <= w_dirUpNext;
      r_phase     <= ~r_phase;
    end
  end

  // --------------------------------------------------------------------------
  // Celebration controller
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= NORMAL;
      r_frameCnt <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_frameCnt <= w_frameNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_frameNext = r_frameCnt;
    case (r_state)
      NORMAL: begin
        w_frameNext = '0;
        if (bus.global_best) begin
          w_stateNext = GB_ANIM;
        end else if (bus.personal_best) begin
          w_stateNext = PB_ANIM;
        end
      end
      PB_ANIM: begin
        if (bus.global_best) begin
          w_stateNext = GB_ANIM;
          w_frameNext = '0;
        end else if (bus.personal_best) begin
          w_frameNext = '0;
        end else if (w_tick) begin
          if (r_frameCnt == c_FRM_LAST) begin
            w_stateNext = NORMAL;
            w_frameNext = '0;
          end else begin
            w_frameNext = r_frameCnt + 1'b1;
          end
        end
      end
      GB_ANIM: begin
        // A personal best cannot interrupt the global-best show.
        if (bus.global_best) begin
          w_frameNext = '0;
        end else if (w_tick) begin
          if (r_frameCnt == c_FRM_LAST) begin
            w_stateNext = NORMAL;
            w_frameNext = '0;
          end else begin
            w_frameNext = r_frameCnt + 1'b1;
          end
        end
      end
      default: begin
        w_stateNext = NORMAL;
        w_frameNext = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // LED pattern generation
  // --------------------------------------------------------------------------
  always_comb begin
    w_popCnt = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      w_popCnt = w_popCnt + c_CNT_W'(bus.gauge_in[i]);
    end
  end

  always_comb begin
    w_ledNext = '0;
    case (r_state)
      GB_ANIM: begin
        w_ledNext = r_frameCnt[0] ? '0 : '1;
      end
      PB_ANIM: begin
        // Even frames light even indices, odd frames light odd indices.
        for (int i = 0; i < N_LEDS; i++) begin
          w_ledNext[i] = (1'(i) == r_frameCnt[0]);
        end
      end
      default: begin
        case (bus.disp_mode)
          3'd0: w_ledNext = bus.gauge_in;
          3'd1: begin
            for (int i = 0; i < N_LEDS; i++) begin
              w_ledNext[i] = (c_CNT_W'(i) < w_popCnt);
            end
          end
          3'd2: begin
            for (int i = 0; i < N_LEDS; i++) begin
              w_ledNext[i] = (c_POS_W'(i) == r_chasePos);
            end
          end
          3'd3: begin
            for (int i = 0; i < N_LEDS; i++) begin
              w_ledNext[i] = (c_POS_W'(i) == r_bouncePos);
            end
          end
          3'd4:    w_ledNext = r_phase ? bus.gauge_in : '0;
          default: w_ledNext = '0;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ledOut   <= '0;
      r_animBusy <= 1'b0;
    end else begin
      r_ledOut   <= w_ledNext;
      r_animBusy <= (w_stateNext != NORMAL);
    end
  end

  assign bus.led_out   = r_ledOut;
  assign bus.anim_busy = r_animBusy;

endmodule
`default_nettype wire
